memory_bus_responder: RTL
=========================

MEMORY_BUS_RESPONDER -- requirements
Module: memory_bus_responder

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, 255, memory response watchdog limit in cycles (1..65535).
REQ-002 clk_i  input  1  sole clock, all logic on rising edge.
REQ-003 rst_i  input  1  synchronous, active-high reset.
REQ-004 flush_i  input  1  pipeline flush; suppresses pending load response.
REQ-005 ld_request_i  input  1  load request, held high by master until ld_valid_o.
REQ-006 ld_address_i  input  32  load byte address.
REQ-007 ld_data_o  output  32  loaded word.
REQ-008 ld_valid_o  output  1  one-cycle load completion pulse.
REQ-009 ld_error_o  output  1  load access fault, qualified by ld_valid_o.
REQ-010 st_request_i  input  1  store request, held high until st_done_o.
REQ-011 st_address_i / st_data_i  input  32 / 32  store byte address / data.
REQ-012 st_width_i  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-013 st_done_o  output  1  one-cycle store completion pulse.
REQ-014 st_error_o  output  1  store access fault, qualified by st_done_o.
REQ-015 mem_req_o, mem_we_o  output  1, 1  memory request, write enable.
REQ-016 mem_addr_o, mem_wdata_o, mem_wstrb_o  output  32, 32, 4  word-aligned address, lane-aligned data, byte strobes.
REQ-017 mem_ready_i, mem_rvalid_i, mem_rdata_i  input  1, 1, 32  request accepted, read data valid, read data.

Function
REQ-018 FSM states SHALL be IDLE, LOAD_WAIT, STORE_WAIT, RESPOND.
REQ-019 In IDLE, ld_request_i SHALL have priority over st_request_i; loser stays pending, served next IDLE.
REQ-020 On acceptance, address/data/width SHALL be latched; master inputs are ignored until completion.
REQ-021 mem_req_o SHALL stay high in *_WAIT from entry until the cycle mem_ready_i=1, then drop.
REQ-022 Load SHALL complete on mem_rvalid_i (same cycle as or after mem_ready_i); mem_rdata_i registered into ld_data_o, FSM to RESPOND.
REQ-023 Store SHALL complete on the mem_ready_i cycle; FSM to RESPOND.
REQ-024 In RESPOND, ld_valid_o or st_done_o SHALL pulse one cycle; next state IDLE; minimum request-to-response latency 2 cycles.
REQ-025 mem_addr_o SHALL be {addr[31:2],2'b00}; strobes: byte 0001<<addr[1:0], half 0011<<{addr[1],1'b0}, word 1111; wdata replicated per lane.
REQ-026 Misaligned store (half with addr[0]=1, word with addr[1:0]!=0) or st_width_i=11 SHALL skip memory, go directly to RESPOND with st_error_o=1.
REQ-027 Misaligned loads are not checked; the word is returned as read.
REQ-028 flush_i during LOAD_WAIT SHALL set a drop flag; transaction finishes on memory side, but ld_valid_o is not pulsed.
REQ-029 flush_i in IDLE or RESPOND-of-load SHALL suppress that cycle's acceptance/pulse; stores SHALL be unaffected by flush_i.
REQ-030 ld_data_o SHALL hold its value until the next load completion.

Reset
REQ-031 rst_i SHALL force IDLE, clear drop flag and timeout counter, and drive all outputs 0 on the next edge, aborting any mid-transaction state.

Configuration
REQ-032 With BUS_TIMEOUT_EN defined, a counter SHALL increment each *_WAIT cycle; reaching TIMEOUT_CYCLES SHALL force RESPOND with ld_error_o/st_error_o=1 and ld_data_o=0.
REQ-033 Without BUS_TIMEOUT_EN, no counter SHALL exist and *_WAIT SHALL wait indefinitely; ld_error_o is tied 0.

Structure
REQ-034 State enum, width encoding and strobe-mask constants SHALL live in a shared package, memory_bus_pkg.
REQ-035 Strobe/lane alignment SHALL be a sub-module, store_lane_aligner (combinational, within the block's line budget).

Verification
REQ-036 Load 0x100, mem ready +1, rvalid +3 data 0xDEADBEEF -> ld_valid_o pulse cycle after rvalid, ld_data_o=0xDEADBEEF, ld_error_o=0.
REQ-037 Byte store 0xAB at 0x203 -> mem_addr_o=0x200, wstrb=1000, wdata=0xABABABAB, st_done_o one cycle after mem_ready_i.
REQ-038 Load and store requested same cycle -> load served first, store accepted on following IDLE, both complete once.
REQ-039 Word store at 0x102 -> no mem_req_o, st_done_o=1 with st_error_o=1 two cycles after request.
REQ-040 Load then flush_i in LOAD_WAIT -> memory transaction finishes, no ld_valid_o; next load completes normally.
REQ-041 BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8, mem_ready_i held 0 -> ld_valid_o with ld_error_o=1 after 8 wait cycles; rst_i mid-wait -> IDLE, outputs 0.

Source files
------------

// File: rtl/memory_bus_pkg.sv
// Shared types and constants for the memory bus responder: FSM states,
// store width encoding, byte-strobe masks and the store alignment rule.
package memory_bus_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    LOAD_WAIT  = 2'b01,
    STORE_WAIT = 2'b10,
    RESPOND    = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    WIDTH_BYTE    = 2'b00,
    WIDTH_HALF    = 2'b01,
    WIDTH_WORD    = 2'b10,
    WIDTH_ILLEGAL = 2'b11
  } width_e;

  localparam logic [3:0] STRB_BYTE = 4'b0001;
  localparam logic [3:0] STRB_HALF = 4'b0011;
  localparam logic [3:0] STRB_WORD = 4'b1111;

  // Stores that cannot be expressed as a single aligned lane access are faulted.
  function automatic logic store_misaligned(input logic [1:0] width,
                                            input logic [1:0] addr_lo);
    case (width)
      WIDTH_BYTE: return 1'b0;
      WIDTH_HALF: return addr_lo[0];
      WIDTH_WORD: return (addr_lo != 2'b00);
      default:    return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_aligner.sv
// Combinational byte-strobe and write-data lane placement for stores.
module store_lane_aligner
  import memory_bus_pkg::*;
(
  input  logic [1:0]        width,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] data,
  output logic [3:0]        wstrb,
  output logic [DATA_W-1:0] wdata
);

  always_comb begin
    wstrb = '0;
    wdata = '0;
    case (width)
      WIDTH_BYTE: begin
        wstrb = STRB_BYTE << addr_lo;
        wdata = {4{data[7:0]}};
      end
      WIDTH_HALF: begin
        wstrb = STRB_HALF << {addr_lo[1], 1'b0};
        wdata = {2{data[15:0]}};
      end
      WIDTH_WORD: begin
        wstrb = STRB_WORD;
        wdata = data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/memory_bus_responder.sv
// Load/store master-to-memory responder FSM (IDLE, LOAD_WAIT, STORE_WAIT, RESPOND).
// Optional watchdog on memory waits enabled by defining BUS_TIMEOUT_EN.
module memory_bus_responder
  import memory_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              ld_request_i,
  input  logic [DATA_W-1:0] ld_address_i,
  output logic [DATA_W-1:0] ld_data_o,
  output logic              ld_valid_o,
  output logic              ld_error_o,
  input  logic              st_request_i,
  input  logic [DATA_W-1:0] st_address_i,
  input  logic [DATA_W-1:0] st_data_i,
  input  logic [1:0]        st_width_i,
  output logic              st_done_o,
  output logic              st_error_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [3:0]        mem_wstrb_o,
  input  logic              mem_ready_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

  state_e            state, state_next;
  logic              is_load, is_load_next;
  logic              drop, drop_next;
  logic              ready_seen, ready_seen_next;
  logic              err, err_next;
  logic              accept_ld, accept_st;
  logic              ld_data_we;
  logic [DATA_W-1:0] ld_data_next;
  logic [DATA_W-1:0] addr_q, wdata_q;
  logic [1:0]        width_q;
  logic [3:0]        strb_aligned;
  logic [DATA_W-1:0] wdata_aligned;
  logic              timeout_hit;

`ifdef BUS_TIMEOUT_EN
  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);
  logic [15:0] tmo_cnt;

  // Counts cycles spent in either wait state; restarts on every new wait.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_cnt <= '0;
    end else if (state == LOAD_WAIT || state == STORE_WAIT) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end else begin
      tmo_cnt <= '0;
    end
  end

  assign timeout_hit = ((tmo_cnt + 16'd1) == TMO_LIMIT);
  assign ld_error_o  = ld_valid_o & err;
`else
  assign timeout_hit = 1'b0;
  assign ld_error_o  = 1'b0;
`endif

  always_comb begin
    state_next      = state;
    is_load_next    = is_load;
    drop_next       = drop;
    ready_seen_next = ready_seen;
    err_next        = err;
    accept_ld       = 1'b0;
    accept_st       = 1'b0;
    ld_data_we      = 1'b0;
    ld_data_next    = mem_rdata_i;
    case (state)
      IDLE: begin
        drop_next       = 1'b0;
        ready_seen_next = 1'b0;
        err_next        = 1'b0;
        // A flushed load is not taken; a pending store may still go this cycle.
        if (ld_request_i && !flush_i) begin
          accept_ld    = 1'b1;
          is_load_next = 1'b1;
          state_next   = LOAD_WAIT;
        end else if (st_request_i) begin
          accept_st    = 1'b1;
          is_load_next = 1'b0;
          if (store_misaligned(st_width_i, st_address_i[1:0])) begin
            err_next   = 1'b1;
            state_next = RESPOND;
          end else begin
            state_next = STORE_WAIT;
          end
        end
      end
      LOAD_WAIT: begin
        if (flush_i)     drop_next       = 1'b1;
        if (mem_ready_i) ready_seen_next = 1'b1;
        if ((ready_seen || mem_ready_i) && mem_rvalid_i) begin
          state_next = RESPOND;
          ld_data_we = !(drop || flush_i);
        end else if (timeout_hit) begin
          state_next   = RESPOND;
          err_next     = 1'b1;
          ld_data_we   = !(drop || flush_i);
          ld_data_next = '0;
        end
      end
      STORE_WAIT: begin
        if (mem_ready_i) begin
          ready_seen_next = 1'b1;
          state_next      = RESPOND;
        end else if (timeout_hit) begin
          err_next   = 1'b1;
          state_next = RESPOND;
        end
      end
      RESPOND: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      is_load    <= 1'b0;
      drop       <= 1'b0;
      ready_seen <= 1'b0;
      err        <= 1'b0;
      ld_data_o  <= '0;
    end else begin
      state      <= state_next;
      is_load    <= is_load_next;
      drop       <= drop_next;
      ready_seen <= ready_seen_next;
      err        <= err_next;
      if (ld_data_we) ld_data_o <= ld_data_next;
    end
  end

  // Request fields are captured on acceptance and held for the whole transaction.
  always_ff @(posedge clk_i) begin
    if (accept_ld) begin
      addr_q <= ld_address_i;
    end else if (accept_st) begin
      addr_q  <= st_address_i;
      wdata_q <= st_data_i;
      width_q <= st_width_i;
    end
  end

  store_lane_aligner u_aligner (
    .width   (width_q),
    .addr_lo (addr_q[1:0]),
    .data    (wdata_q),
    .wstrb   (strb_aligned),
    .wdata   (wdata_aligned)
  );

  assign mem_req_o   = (state == LOAD_WAIT || state == STORE_WAIT) && !ready_seen;
  assign mem_we_o    = mem_req_o && (state == STORE_WAIT);
  assign mem_addr_o  = mem_req_o ? {addr_q[DATA_W-1:2], 2'b00} : '0;
  assign mem_wstrb_o = mem_we_o ? strb_aligned : 4'b0000;
  assign mem_wdata_o = mem_we_o ? wdata_aligned : '0;

  assign ld_valid_o = (state == RESPOND) && is_load && !drop && !flush_i;
  assign st_done_o  = (state == RESPOND) && !is_load;
  assign st_error_o = st_done_o && err;

endmodule
